// File: rtl/sseg_scan_capture.sv
// sseg_scan_capture
//   Receive-side monitor for a time-multiplexed 7-segment bus. It rebuilds
//   the four per-digit segment patterns from the shared anode/segment lines,
//   filters out transients, flags illegal anode patterns, reports frame
//   completion and reports a scan that has stopped.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   an[3:0]    in   anode enables, active-low, one digit low at a time
//   sseg[7:0]  in   segment bus, active-low, bit 7 = decimal point
//   clear      in   synchronous clear of capture status
//   out0..3    out  last captured pattern of digit 0..3
//   dig_valid  out  digit k captured since reset/clear/timeout
//   frame_done out  one-cycle pulse when all four digits were captured
//   an_err     out  one-cycle pulse on a stable anode pattern with >1 low
//   stale      out  no capture for 2^TIMEOUT_W-1 cycles
module sseg_scan_capture #(
    parameter int unsigned SETTLE    = 4,
    parameter int unsigned TIMEOUT_W = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] an,
    input  logic [7:0] sseg,
    input  logic       clear,
    output logic [7:0] out0,
    output logic [7:0] out1,
    output logic [7:0] out2,
    output logic [7:0] out3,
    output logic [3:0] dig_valid,
    output logic       frame_done,
    output logic       an_err,
    output logic       stale
);

    localparam logic [3:0]           SETTLE_C = 4'(SETTLE);
    localparam logic [3:0]           SETTLE_P = 4'(SETTLE - 1);
    localparam logic [TIMEOUT_W-1:0] IDLE_MAX = '1;
    localparam logic [TIMEOUT_W-1:0] IDLE_PRE = IDLE_MAX - TIMEOUT_W'(1);

    logic [3:0]           samp_an;
    logic [7:0]           samp_sseg;
    logic [3:0]           stab_cnt;
    logic                 cap;
    logic [TIMEOUT_W-1:0] idle;
    logic [3:0]           seen;
    logic [7:0]           digs [4];

    logic                 hit_valid;
    logic                 hit_err;
    logic [1:0]           hit_idx;
    logic [3:0]           seen_next;

    // Sample register and stability filter. cap is a one-cycle strobe that
    // is raised on the edge where the counter reaches SETTLE, so the capture
    // acts on the following edge using the still-held sample register.
    always_ff @(posedge clk) begin
        samp_an   <= an;
        samp_sseg <= sseg;
        if (reset) begin
            stab_cnt <= '0;
            cap      <= 1'b0;
        end else if ({an, sseg} != {samp_an, samp_sseg}) begin
            stab_cnt <= '0;
            cap      <= 1'b0;
        end else begin
            if (stab_cnt != SETTLE_C)
                stab_cnt <= stab_cnt + 4'd1;
            cap <= (stab_cnt == SETTLE_P);
        end
    end

    // Classify the captured anode pattern.
    always_comb begin
        hit_valid = 1'b0;
        hit_err   = 1'b0;
        hit_idx   = 2'd0;
        if (cap) begin
            case (samp_an)
                4'b1110: begin hit_valid = 1'b1; hit_idx = 2'd0; end
                4'b1101: begin hit_valid = 1'b1; hit_idx = 2'd1; end
                4'b1011: begin hit_valid = 1'b1; hit_idx = 2'd2; end
                4'b0111: begin hit_valid = 1'b1; hit_idx = 2'd3; end
                4'b1111: ;
                default: hit_err = 1'b1;
            endcase
        end
        seen_next = seen | (4'b0001 << hit_idx);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 4; i++)
                digs[i] <= 8'hFF;
            dig_valid  <= '0;
            seen       <= '0;
            frame_done <= 1'b0;
            an_err     <= 1'b0;
            stale      <= 1'b0;
            idle       <= '0;
        end else begin
            frame_done <= 1'b0;
            an_err     <= hit_err;
            // The pattern register updates even when clear discards the
            // status side effects of the same capture.
            if (hit_valid)
                digs[hit_idx] <= samp_sseg;
            if (clear) begin
                dig_valid <= '0;
                seen      <= '0;
                stale     <= 1'b0;
                idle      <= '0;
            end else begin
                if (hit_valid || hit_err)
                    idle <= '0;
                else if (idle != IDLE_MAX)
                    idle <= idle + TIMEOUT_W'(1);

                if (hit_valid) begin
                    dig_valid[hit_idx] <= 1'b1;
                    stale              <= 1'b0;
                    if (seen_next == 4'b1111) begin
                        frame_done <= 1'b1;
                        seen       <= '0;
                    end else begin
                        seen <= seen_next;
                    end
                end else if (!hit_err && idle == IDLE_PRE) begin
                    stale     <= 1'b1;
                    dig_valid <= '0;
                    seen      <= '0;
                end
            end
        end
    end

    assign out0 = digs[0];
    assign out1 = digs[1];
    assign out2 = digs[2];
    assign out3 = digs[3];

endmodule

// File: tb/tb_sseg_scan_capture.sv
// tb_sseg_scan_capture
//   Scoreboard bench: a reference model reacting to every clock edge pushes
//   the expected output vector into a queue; a monitor on the falling edge
//   pops it and compares with the DUT. Directed phases follow the test plan,
//   then a randomized scan phase runs.
module tb_sseg_scan_capture;

    localparam int unsigned SETTLE = 4;
    localparam int unsigned TW     = 8;
    localparam int unsigned MAXIDLE = (1 << TW) - 1;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] an;
    logic [7:0] sseg;
    logic       clear;
    logic [7:0] out0, out1, out2, out3;
    logic [3:0] dig_valid;
    logic       frame_done, an_err, stale;

    int checks = 0;
    int errors = 0;
    int fd_seen = 0;
    int err_seen = 0;

    typedef struct packed {
        logic [31:0] outs;
        logic [3:0]  dv;
        logic        fd;
        logic        err;
        logic        stale;
    } exp_t;

    exp_t sb[$];

    sseg_scan_capture #(.SETTLE(SETTLE), .TIMEOUT_W(TW)) dut (
        .clk(clk), .reset(reset), .an(an), .sseg(sseg), .clear(clear),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .dig_valid(dig_valid), .frame_done(frame_done), .an_err(an_err),
        .stale(stale)
    );

    always #5 clk = ~clk;

    // Reference model: a capture happens when the most recent samples form
    // a run of exactly SETTLE+1 identical values (the run started at a
    // change or at the last reset edge).
    logic [11:0] hist[$];
    logic [7:0]  m_out [4];
    logic [3:0]  m_dv, m_seen;
    logic        m_stale, m_fd, m_err;
    int          m_since;

    always @(posedge clk) begin
        logic [11:0] cur, v;
        int run, lows, k;
        logic cap_now, valid, bad;
        cur = {an, sseg};
        if (reset) begin
            hist.delete();
            hist.push_back(cur);
            for (int i = 0; i < 4; i++) m_out[i] = 8'hFF;
            m_dv = 4'h0; m_seen = 4'h0; m_stale = 1'b0;
            m_fd = 1'b0; m_err = 1'b0; m_since = 0;
        end else begin
            run = 0;
            v = hist[hist.size()-1];
            for (int i = hist.size() - 1; i >= 0; i--) begin
                if (hist[i] == v) run++;
                else break;
            end
            cap_now = (run == SETTLE + 1);
            hist.push_back(cur);
            if (hist.size() > SETTLE + 2) void'(hist.pop_front());
            lows = $countones(~v[11:8]);
            k = 0;
            for (int i = 0; i < 4; i++) if (!v[8+i]) k = i;
            valid = cap_now && (lows == 1);
            bad   = cap_now && (lows >= 2);
            m_fd  = 1'b0;
            m_err = bad;
            if (valid) m_out[k] = v[7:0];
            if (clear) begin
                m_dv = 4'h0; m_seen = 4'h0; m_stale = 1'b0; m_since = 0;
            end else if (valid || bad) begin
                m_since = 0;
                if (valid) begin
                    m_dv[k] = 1'b1;
                    m_stale = 1'b0;
                    m_seen[k] = 1'b1;
                    if (m_seen == 4'hF) begin
                        m_fd = 1'b1;
                        m_seen = 4'h0;
                    end
                end
            end else if (m_since < MAXIDLE) begin
                m_since++;
                if (m_since == MAXIDLE) begin
                    m_stale = 1'b1; m_dv = 4'h0; m_seen = 4'h0;
                end
            end
        end
        sb.push_back('{outs: {m_out[3], m_out[2], m_out[1], m_out[0]},
                       dv: m_dv, fd: m_fd, err: m_err, stale: m_stale});
    end

    // Monitor
    always @(negedge clk) begin
        exp_t e, g;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            g = '{outs: {out3, out2, out1, out0}, dv: dig_valid,
                  fd: frame_done, err: an_err, stale: stale};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL scoreboard t=%0t got outs=%h dv=%b fd=%b err=%b stale=%b exp outs=%h dv=%b fd=%b err=%b stale=%b",
                         $time, g.outs, g.dv, g.fd, g.err, g.stale,
                         e.outs, e.dv, e.fd, e.err, e.stale);
            end
        end
        if (frame_done === 1'b1) fd_seen++;
        if (an_err === 1'b1) err_seen++;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
        an = a;
        sseg = s;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fd0, er0, n;
        logic [3:0] a;
        reset = 1'b1; clear = 1'b0; an = 4'hF; sseg = 8'hFF;
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;

        hold(4'b1111, 8'hFF, 2);
        chk("reset_outs", {out3, out2, out1, out0}, 32'hFFFF_FFFF);
        chk("reset_dv", {28'h0, dig_valid}, 32'h0);
        chk("reset_stale", {31'h0, stale}, 32'h0);

        hold(4'b1110, 8'hAA, 5);
        chk("settle_not_yet", {24'h0, out0}, 32'hFF);
        hold(4'b1110, 8'hAA, 1);
        chk("settle_capture", {24'h0, out0}, 32'hAA);
        hold(4'b1110, 8'hAA, 4);
        chk("single_dv", {28'h0, dig_valid}, 32'h1);

        fd0 = fd_seen;
        for (int p = 0; p < 2; p++) begin
            hold(4'b1110, 8'hAA, 8);
            hold(4'b1101, 8'h55, 8);
            hold(4'b1011, 8'hF0, 8);
            hold(4'b0111, 8'h0F, 8);
        end
        chk("scan_outs", {out3, out2, out1, out0}, 32'h0FF0_55AA);
        chk("scan_dv", {28'h0, dig_valid}, 32'hF);
        chk("scan_frames", fd_seen - fd0, 32'd2);

        hold(4'b1101, 8'h55, 3);
        hold(4'b1101, 8'h54, 3);
        chk("glitch_out1", {24'h0, out1}, 32'h55);
        chk("glitch_dv", {28'h0, dig_valid}, 32'hF);

        er0 = err_seen;
        hold(4'b1100, 8'h12, 6);
        hold(4'b1111, 8'hFF, 255);
        chk("anerr_pulses", err_seen - er0, 32'd1);
        chk("stale_set", {31'h0, stale}, 32'h1);
        chk("stale_dv", {28'h0, dig_valid}, 32'h0);
        chk("stale_outs", {out3, out2, out1, out0}, 32'h0FF0_55AA);

        fd0 = fd_seen;
        hold(4'b0111, 8'h3C, 5);
        clear = 1'b1;
        hold(4'b0111, 8'h3C, 1);
        clear = 1'b0;
        hold(4'b0111, 8'h3C, 2);
        chk("clear_out3", {24'h0, out3}, 32'h3C);
        chk("clear_dv", {28'h0, dig_valid}, 32'h0);
        chk("clear_stale", {31'h0, stale}, 32'h0);
        hold(4'b1011, 8'h99, 8);
        chk("after_clear_dv", {28'h0, dig_valid}, 32'h4);
        chk("clear_no_frame", fd_seen - fd0, 32'd0);

        // Randomized scan with glitches, illegal anodes, clears and resets.
        for (int it = 0; it < 400; it++) begin
            case ($urandom_range(0, 19))
                0, 1, 2:  a = 4'b1111;
                3, 4, 5:  a = 4'($urandom_range(0, 15));
                default:  a = ~(4'b0001 << $urandom_range(0, 3));
            endcase
            an = a;
            sseg = 8'($urandom);
            n = $urandom_range(1, 9);
            for (int c = 0; c < n; c++) begin
                clear = ($urandom_range(0, 29) == 0);
                reset = ($urandom_range(0, 199) == 0);
                @(posedge clk);
                #1;
                clear = 1'b0;
                reset = 1'b0;
            end
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        if (sb.size() > 1) begin
            errors++;
            $display("FAIL queue_drain got %0d exp <=1", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sseg_scan_capture.md
Name: sseg_scan_capture

Overview:
- Receive-side counterpart to the 7-segment time-multiplexing driver.
- Watches the multiplexed anode/segment bus (an, sseg) and rebuilds the four per-digit segment patterns into stable registers.
- Used as a loop-back checker on the board and as a self-checking monitor in simulation.
- Applies a stability filter, validates the anode pattern, tracks frame completion, and flags a stalled scan.

Parameters:
SETTLE, 4, number of extra identical consecutive samples required before capture (legal range 1..15)
TIMEOUT_W, 20, width of the idle counter; stale asserts after 2^TIMEOUT_W-1 cycles with no capture

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
an  in  4  anode enables, active-low, one digit expected low at a time
sseg  in  8  segment bus, active-low, bit 7 = decimal point
clear  in  1  synchronous clear of capture status (single-cycle pulse or level)
out0  out  8  last captured pattern for digit 0 (an[0] low)
out1  out  8  last captured pattern for digit 1
out2  out  8  last captured pattern for digit 2
out3  out  8  last captured pattern for digit 3
dig_valid  out  4  bit k set once digit k has been captured since reset/clear/timeout
frame_done  out  1  one-cycle pulse when all four digits have been captured in the current frame
an_err  out  1  one-cycle pulse when a stable an has more than one low bit
stale  out  1  high when no capture has occurred for 2^TIMEOUT_W-1 cycles

Behaviour:
- Reset (synchronous, active-high): out0..out3=8'hFF (segments off), dig_valid=0, frame_done=0, an_err=0, stale=0. The stability counter, seen mask and idle counter clear. Reset asserted mid-window discards the window.
- Sampling: {an,sseg} is registered every cycle. The stability counter clears whenever a sample differs from the previous sample. Otherwise the counter increments and saturates at SETTLE.
- A capture event fires exactly once per stable window: on the cycle the counter reaches SETTLE, i.e. after SETTLE+1 identical samples.
- Capture latency: if the pins are held from before edge e0 through edge e_SETTLE, outputs update on edge e_(SETTLE+1). There is no second capture while the value stays held.
- Classification at the capture event:
  - an one-hot-low (1110, 1101, 1011, 0111): outK<=sseg, dig_valid[K]<=1, seen[K]<=1.
  - an=4'b1111 (blank): no action.
  - Any other an (two or more lows): an_err pulses for 1 cycle. Outputs, dig_valid and seen are unchanged.
- Frame logic:
  - When a capture makes seen==4'b1111, frame_done pulses on that same update edge and seen returns to 0.
  - Repeat captures of a digit already in seen do not affect frame logic.
- Idle counter:
  - Clears on every capture event (including an_err captures).
  - Otherwise increments and saturates at 2^TIMEOUT_W-1.
  - On reaching that value: stale<=1, dig_valid<=0, seen<=0. out0..out3 hold their values.
  - The next valid capture drops stale to 0 on its update edge.
- clear: dig_valid<=0, seen<=0, stale<=0, idle counter<=0. outK hold. clear does not reset the stability counter.
- Simultaneous events:
  - clear and capture in the same cycle: clear wins; the capture's dig_valid/seen/frame_done effects are discarded, but outK still updates.
  - Timeout and capture in the same cycle: capture wins; the idle counter restarts and stale stays 0.
- Width rules: the stability counter is at least 4 bits wide; the idle counter is TIMEOUT_W bits; no arithmetic overflow or wrap is allowed (both counters saturate).

Test Plan:
All scenarios run with SETTLE=4, TIMEOUT_W=8.
- Reset held 5 cycles, then released with an=1111 -> out0..3=FF, dig_valid=0000, stale=0, no pulses.
- an=1110, sseg=8'hAA held 10 cycles -> out0=AA on the 6th edge after the first sample, dig_valid=0001, no frame_done, exactly one update.
- Scan digits 0..3 with AA, 55, F0, 0F, 8 cycles each, repeated twice -> outs=AA/55/F0/0F, dig_valid=1111, frame_done pulses exactly once per pass (twice total), one cycle after the digit-3 capture edge.
- Glitch: an=1101, sseg=55 held 3 cycles, then sseg=54 held 3 cycles -> no capture, out1 unchanged, dig_valid unchanged.
- an=1100 held 6 cycles -> single an_err pulse, outs and dig_valid unchanged; then an=1111 held 255 cycles -> stale=1, dig_valid=0000, outs hold AA/55/F0/0F.
- clear asserted on the capture edge of an=0111, sseg=3C -> out3=3C, dig_valid=0000, no frame_done; a new capture afterwards sets only its own bit.
